// File: rtl/vec_match_pkg.sv
// Shared constants and state encoding for the vector match pipeline.
package vec_match_pkg;

    localparam int VEC_WIDTH    = 1100;
    localparam int POPCNT_WIDTH = 11;
    localparam int LIB_DEPTH    = 1024;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_e;

    // Index width for a library of the given depth, never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vec_best_track.sv
// Best (and, with VEC_BEST_SECOND_EN, runner-up) count/index register bank.
// The pre-register best count is exported so the caller can evaluate it on the final beat.
module vec_best_track
    import vec_match_pkg::*;
#(
    parameter int POPCNT_WIDTH = vec_match_pkg::POPCNT_WIDTH,
    parameter int IDX_WIDTH    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept,
    input  logic                    first,
    input  logic [IDX_WIDTH-1:0]    idx,
    input  logic [POPCNT_WIDTH-1:0] count,
    output logic [IDX_WIDTH-1:0]    best_idx,
    output logic [POPCNT_WIDTH-1:0] best_count,
    output logic [POPCNT_WIDTH-1:0] best_count_nxt
`ifdef VEC_BEST_SECOND_EN
    ,
    output logic [IDX_WIDTH-1:0]    second_idx,
    output logic [POPCNT_WIDTH-1:0] second_count
`endif
);

    logic [IDX_WIDTH-1:0]    best_idx_r, best_idx_nxt_s;
    logic [POPCNT_WIDTH-1:0] best_count_r, best_count_nxt_s;
`ifdef VEC_BEST_SECOND_EN
    logic [IDX_WIDTH-1:0]    second_idx_r, second_idx_nxt_s;
    logic [POPCNT_WIDTH-1:0] second_count_r, second_count_nxt_s;
`endif

    // Next-state of the tracker; strict compares keep the lower index on ties.
    always_comb begin
        best_idx_nxt_s     = best_idx_r;
        best_count_nxt_s   = best_count_r;
`ifdef VEC_BEST_SECOND_EN
        second_idx_nxt_s   = second_idx_r;
        second_count_nxt_s = second_count_r;
`endif
        if (accept && first) begin
            best_idx_nxt_s     = {IDX_WIDTH{1'b0}};
            best_count_nxt_s   = count;
`ifdef VEC_BEST_SECOND_EN
            second_idx_nxt_s   = {IDX_WIDTH{1'b0}};
            second_count_nxt_s = {POPCNT_WIDTH{1'b0}};
`endif
        end else if (accept && (count > best_count_r)) begin
            best_idx_nxt_s     = idx;
            best_count_nxt_s   = count;
`ifdef VEC_BEST_SECOND_EN
            second_idx_nxt_s   = best_idx_r;
            second_count_nxt_s = best_count_r;
        end else if (accept && (count > second_count_r)) begin
            second_idx_nxt_s   = idx;
            second_count_nxt_s = count;
`endif
        end else begin
            best_idx_nxt_s     = best_idx_r;
            best_count_nxt_s   = best_count_r;
        end
    end

    // Tracker registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_idx_r     <= {IDX_WIDTH{1'b0}};
            best_count_r   <= {POPCNT_WIDTH{1'b0}};
`ifdef VEC_BEST_SECOND_EN
            second_idx_r   <= {IDX_WIDTH{1'b0}};
            second_count_r <= {POPCNT_WIDTH{1'b0}};
`endif
        end else begin
            best_idx_r     <= best_idx_nxt_s;
            best_count_r   <= best_count_nxt_s;
`ifdef VEC_BEST_SECOND_EN
            second_idx_r   <= second_idx_nxt_s;
            second_count_r <= second_count_nxt_s;
`endif
        end
    end

    assign best_idx       = best_idx_r;
    assign best_count     = best_count_r;
    assign best_count_nxt = best_count_nxt_s;
`ifdef VEC_BEST_SECOND_EN
    assign second_idx     = second_idx_r;
    assign second_count   = second_count_r;
`endif

endmodule

// File: rtl/vec_best_select.sv
// Frame-wise arg-max over the match-count stream with a registered result beat.
// Optional runner-up outputs are enabled by defining VEC_BEST_SECOND_EN.
module vec_best_select
    import vec_match_pkg::*;
#(
    parameter int POPCNT_WIDTH = vec_match_pkg::POPCNT_WIDTH,
    parameter int LIB_DEPTH    = vec_match_pkg::LIB_DEPTH,
    parameter int IDX_WIDTH    = idx_width(LIB_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    this_ready,
    input  logic [POPCNT_WIDTH-1:0] match_count,
    input  logic [POPCNT_WIDTH-1:0] thresh,
    output logic                    out_valid,
    input  logic                    next_ready,
    output logic [IDX_WIDTH-1:0]    best_idx,
    output logic [POPCNT_WIDTH-1:0] best_count,
    output logic                    found
`ifdef VEC_BEST_SECOND_EN
    ,
    output logic [IDX_WIDTH-1:0]    second_idx,
    output logic [POPCNT_WIDTH-1:0] second_count
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LIB_DEPTH - 1);

    state_e                  state_r;
    logic [IDX_WIDTH-1:0]    idx_cnt_r;
    logic [POPCNT_WIDTH-1:0] thr_q_r;
    logic [POPCNT_WIDTH-1:0] thr_nxt_s;
    logic [POPCNT_WIDTH-1:0] best_count_nxt_s;
    logic                    this_ready_r;
    logic                    out_valid_r;
    logic                    found_r;
    logic                    accept_s;
    logic                    first_s;
    logic                    last_s;

    assign accept_s = in_valid && this_ready_r && (state_r == ST_ACCUM);
    assign first_s  = (idx_cnt_r == {IDX_WIDTH{1'b0}});
    assign last_s   = (idx_cnt_r == LAST_IDX);

    // The threshold seen by the final compare must include a same-cycle first-beat load.
    always_comb begin
        if (accept_s && first_s) begin
            thr_nxt_s = thresh;
        end else begin
            thr_nxt_s = thr_q_r;
        end
    end

    vec_best_track #(
        .POPCNT_WIDTH (POPCNT_WIDTH),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_track (
        .clk            (clk),
        .rst            (rst),
        .accept         (accept_s),
        .first          (first_s),
        .idx            (idx_cnt_r),
        .count          (match_count),
        .best_idx       (best_idx),
        .best_count     (best_count),
        .best_count_nxt (best_count_nxt_s)
`ifdef VEC_BEST_SECOND_EN
        ,
        .second_idx     (second_idx),
        .second_count   (second_count)
`endif
    );

    // Frame FSM, entry counter and registered handshake/result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_ACCUM;
            idx_cnt_r    <= {IDX_WIDTH{1'b0}};
            thr_q_r      <= {POPCNT_WIDTH{1'b0}};
            this_ready_r <= 1'b0;
            out_valid_r  <= 1'b0;
            found_r      <= 1'b0;
        end else begin
            thr_q_r <= thr_nxt_s;
            case (state_r)
                ST_ACCUM: begin
                    this_ready_r <= 1'b1;
                    if (accept_s && last_s) begin
                        idx_cnt_r    <= {IDX_WIDTH{1'b0}};
                        state_r      <= ST_OUT;
                        this_ready_r <= 1'b0;
                        out_valid_r  <= 1'b1;
                        found_r      <= (best_count_nxt_s >= thr_nxt_s);
                    end else if (accept_s) begin
                        idx_cnt_r <= idx_cnt_r + IDX_WIDTH'(1);
                    end
                end
                ST_OUT: begin
                    if (next_ready) begin
                        state_r      <= ST_ACCUM;
                        out_valid_r  <= 1'b0;
                        this_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_ACCUM;
                    idx_cnt_r    <= {IDX_WIDTH{1'b0}};
                    this_ready_r <= 1'b0;
                    out_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign this_ready = this_ready_r;
    assign out_valid  = out_valid_r;
    assign found      = found_r;

endmodule

// File: tb/tb_vec_best_select.sv
// Directed and randomized frames against an arg-max reference model (LIB_DEPTH=4).
module tb_vec_best_select;

    localparam int PW    = 11;
    localparam int DEPTH = 4;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          this_ready;
    logic [PW-1:0] match_count;
    logic [PW-1:0] thresh;
    logic          out_valid;
    logic          next_ready;
    logic [IW-1:0] best_idx;
    logic [PW-1:0] best_count;
    logic          found;
`ifdef VEC_BEST_SECOND_EN
    logic [IW-1:0] second_idx;
    logic [PW-1:0] second_count;
`endif

    int n_vec = 0;
    int n_mis = 0;

    vec_best_select #(
        .POPCNT_WIDTH (PW),
        .LIB_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .this_ready   (this_ready),
        .match_count  (match_count),
        .thresh       (thresh),
        .out_valid    (out_valid),
        .next_ready   (next_ready),
        .best_idx     (best_idx),
        .best_count   (best_count),
        .found        (found)
`ifdef VEC_BEST_SECOND_EN
        ,
        .second_idx   (second_idx),
        .second_count (second_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index of the maximum; runner-up is the best of the remaining entries.
    task automatic model(input int c[DEPTH], input int thr,
                         output int bi, output int bc, output int f,
                         output int si, output int sc);
        bc = -1;
        bi = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (c[i] > bc) begin
                bc = c[i];
                bi = i;
            end
        end
        f  = (bc >= thr) ? 1 : 0;
        sc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != bi && c[i] > sc) sc = c[i];
        end
        si = 0;
        if (sc != 0) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (i != bi && c[i] == sc) si = i;
            end
        end
    endtask

    task automatic send_beat(input int c, input int t, input int gap);
        bit done = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_valid    = 1'b0;
            match_count = PW'($urandom);
            cyc();
        end
        in_valid    = 1'b1;
        match_count = PW'(c);
        thresh      = PW'(t);
        for (int n = 0; n < 50 && !done; n++) begin
            if (this_ready) done = 1'b1;
            cyc();
        end
        if (!done) chk("beat_timeout", 32'd0, 32'd1);
        in_valid    = 1'b0;
        match_count = PW'($urandom);
        thresh      = PW'($urandom);
    endtask

    task automatic run_frame(input string tag, input int c[DEPTH], input int thr,
                             input int max_gap, input int hold);
        int bi, bc, f, si, sc;
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(c[i], thr, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        model(c, thr, bi, bc, f, si, sc);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ready_out"}, 32'(this_ready), 32'd0);
        chk({tag, "_bidx"}, 32'(best_idx), bi);
        chk({tag, "_bcnt"}, 32'(best_count), bc);
        chk({tag, "_found"}, 32'(found), f);
`ifdef VEC_BEST_SECOND_EN
        chk({tag, "_sidx"}, 32'(second_idx), si);
        chk({tag, "_scnt"}, 32'(second_count), sc);
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid    = 1'b1;
            match_count = PW'($urandom);
            cyc();
            chk({tag, "_hold_ovalid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(this_ready), 32'd0);
            chk({tag, "_hold_bidx"}, 32'(best_idx), bi);
            chk({tag, "_hold_bcnt"}, 32'(best_count), bc);
            chk({tag, "_hold_found"}, 32'(found), f);
        end
        in_valid   = 1'b0;
        next_ready = 1'b1;
        cyc();
        next_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(this_ready), 32'd1);
    endtask

    initial begin
        int fr[DEPTH];
        rst         = 1'b1;
        in_valid    = 1'b0;
        next_ready  = 1'b0;
        match_count = '0;
        thresh      = '0;
        cyc();
        cyc();
        chk("rst_ready", 32'(this_ready), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_bidx", 32'(best_idx), 32'd0);
        chk("rst_bcnt", 32'(best_count), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
`ifdef VEC_BEST_SECOND_EN
        chk("rst_sidx", 32'(second_idx), 32'd0);
        chk("rst_scnt", 32'(second_count), 32'd0);
`endif
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", 32'(this_ready), 32'd1);

        fr = '{5, 9, 3, 7};
        run_frame("f_basic", fr, 8, 0, 0);
        fr = '{6, 6, 2, 6};
        run_frame("f_ties", fr, 7, 0, 0);
        fr = '{0, 0, 0, 0};
        run_frame("f_zero_t0", fr, 0, 0, 0);
        run_frame("f_zero_t1", fr, 1, 0, 0);

        fr = '{int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047))};
        run_frame("f_stall", fr, int'($urandom_range(0, 2047)), 0, 5);
        fr = '{1, 2, 3, 4};
        run_frame("f_after_stall", fr, 3, 0, 0);

        fr = '{2047, 0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047))};
        run_frame("f_max0", fr, 2047, 3, 0);
        fr = '{1, 2047, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047))};
        run_frame("f_max1", fr, 2000, 3, 0);

        send_beat(9, 3, 0);
        send_beat(12, 3, 0);
        rst = 1'b1;
        cyc();
        chk("midrst_ready", 32'(this_ready), 32'd0);
        chk("midrst_ovalid", 32'(out_valid), 32'd0);
        chk("midrst_bidx", 32'(best_idx), 32'd0);
        chk("midrst_bcnt", 32'(best_count), 32'd0);
        chk("midrst_found", 32'(found), 32'd0);
        rst = 1'b0;
        cyc();
        fr = '{4, 1, 1, 1};
        run_frame("f_after_rst", fr, 4, 0, 0);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                fr[i] = (k % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2047));
            end
            run_frame("f_rand", fr, int'($urandom_range(0, (k % 2 == 0) ? 4 : 2047)),
                      2, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
